// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with press/release debounce,
// one event per press and the two most recent key codes.
module keypad_scanner #(
    parameter int SCAN_DIV        = 4096,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    // nibble {row, col} holds the legend printed on that key
    localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t        state, state_n;
    logic [3:0]    col_m, col_s;
    logic [1:0]    row_idx, row_idx_n, lc, lc_n, low_col;
    logic [DW-1:0] dwell, dwell_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          fire, pressed;
    logic [3:0]    code;

    assign low_col = !col_s[0] ? 2'd0 : !col_s[1] ? 2'd1 : !col_s[2] ? 2'd2 : 2'd3;
    assign pressed = !col_s[lc];
    assign code    = KEY_MAP[{row_idx, lc, 2'b00} +: 4];

    always_comb begin
        state_n   = state;
        row_idx_n = row_idx;
        lc_n      = lc;
        dwell_n   = dwell;
        cnt_n     = cnt;
        fire      = 1'b0;
        case (state)
            SCAN: begin
                if (dwell != DWELL_LAST) begin
                    dwell_n = dwell + 1'b1;
                end else begin
                    dwell_n = '0;
                    if (col_s != 4'hF) begin
                        state_n = DEBOUNCE;
                        lc_n    = low_col;
                        cnt_n   = '0;
                    end else begin
                        row_idx_n = row_idx + 2'd1;
                    end
                end
            end
            DEBOUNCE: begin
                if (!pressed) state_n = SCAN;
                else if (cnt == CNT_LAST) begin
                    state_n = HELD;
                    fire    = 1'b1;
                end else cnt_n = cnt + 1'b1;
            end
            HELD: begin
                if (!pressed) begin
                    state_n = RELEASE;
                    cnt_n   = '0;
                end
            end
            RELEASE: begin
                if (pressed) state_n = HELD;
                else if (cnt == CNT_LAST) state_n = SCAN;
                else cnt_n = cnt + 1'b1;
            end
            default: state_n = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SCAN;
            col_m     <= 4'hF;
            col_s     <= 4'hF;
            row_idx   <= '0;
            lc        <= '0;
            dwell     <= '0;
            cnt       <= '0;
            row       <= 4'b1110;
            key_valid <= 1'b0;
            key_code  <= '0;
            digit_new <= '0;
            digit_old <= '0;
        end else begin
            state     <= state_n;
            col_m     <= col;
            col_s     <= col_m;
            row_idx   <= row_idx_n;
            lc        <= lc_n;
            dwell     <= dwell_n;
            cnt       <= cnt_n;
            row       <= ~(4'b0001 << row_idx_n);
            key_valid <= fire;
            if (fire) begin
                key_code  <= code;
                digit_old <= digit_new;
                digit_new <= code;
            end
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad model driving columns from the scanned row, table
// vectors, timed corner sequences and randomized presses with bounce.
module tb_keypad_scanner;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] col, row, key_code, digit_new, digit_old;
    logic       key_valid;
    logic [15:0] keys = '0;
    int n_cmp = 0, n_fail = 0, n_ev = 0, exp_ev = 0;
    logic [3:0] last_code = '0;
    logic       prev_valid = 1'b0;

    logic [3:0] kmap [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                '{4'h4, 4'h5, 4'h6, 4'hB},
                                '{4'h7, 4'h8, 4'h9, 4'hC},
                                '{4'hE, 4'h0, 4'hF, 4'hD}};

    typedef struct {int r; int c; logic [3:0] code;} vec_t;
    vec_t tbl [15];

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(8), .DEBOUNCE_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .col(col), .row(row), .key_valid(key_valid),
        .key_code(key_code), .digit_new(digit_new), .digit_old(digit_old)
    );

    // a pressed key shorts its column to its row while that row is driven low
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
    end

    function automatic logic [15:0] kbit(input int r, input int c);
        return 16'(1) << (r * 4 + c);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // every cycle: one row low, single-cycle pulses, digits shift the last two events
    task automatic step();
        @(negedge clk);
        chk("row_one_cold", $countones(~row), 1);
        if (key_valid) begin
            chk("pulse_width", int'(prev_valid), 0);
            chk("digit_new_on_event", digit_new, key_code);
            chk("digit_old_on_event", digit_old, last_code);
            last_code = key_code;
            n_ev++;
        end
        prev_valid = key_valid;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        last_code = '0;
    endtask

    task automatic wait_pulse(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            step();
            n++;
            if (key_valid) return;
        end
        n = -1;
    endtask

    initial begin
        int n, r, c, nb;
        logic [3:0] er, pr;
        tbl = '{'{0,0,4'h1}, '{0,1,4'h2}, '{0,2,4'h3}, '{1,0,4'h4}, '{1,2,4'h6},
                '{1,3,4'hB}, '{2,0,4'h7}, '{2,1,4'h8}, '{2,3,4'hC}, '{3,0,4'hE},
                '{3,1,4'h0}, '{3,2,4'hF}, '{3,3,4'hD}, '{2,2,4'h9}, '{0,3,4'hA}};

        do_reset();
        chk("reset_row", row, 4'b1110);
        chk("reset_key_valid", key_valid, 0);
        chk("reset_key_code", key_code, 0);
        chk("reset_digit_new", digit_new, 0);
        chk("reset_digit_old", digit_old, 0);

        for (int k = 0; k < 64; k++) begin
            er = ~(4'b0001 << ((k / 8) % 4));
            chk("idle_row", row, er);
            chk("idle_key_valid", key_valid, 0);
            step();
        end

        // "5": row 1 is driven from cycle 72, sampled at 80, event 16 later
        keys = kbit(1, 1);
        wait_pulse(60, n);
        exp_ev++;
        chk("press5_latency", n, 32);
        chk("press5_code", key_code, 5);
        chk("press5_digit_new", digit_new, 5);
        chk("press5_digit_old", digit_old, 0);
        for (int i = 0; i < 200; i++) begin
            step();
            chk("press5_row_held", row, 4'b1101);
        end
        keys = '0;
        for (int i = 1; i <= 30; i++) begin
            step();
            chk("press5_release_row", row, i < 27 ? 4'b1101 : 4'b1011);
        end
        chk("press5_events", n_ev, exp_ev);

        foreach (tbl[i]) begin
            keys = kbit(tbl[i].r, tbl[i].c);
            wait_pulse(50, n);
            exp_ev++;
            chk("tbl_pulse_in_time", int'(n > 0), 1);
            chk("tbl_code", key_code, tbl[i].code);
            repeat (20) step();
            keys = '0;
            repeat (30) step();
            chk("tbl_events", n_ev, exp_ev);
        end
        chk("two_press_digit_new", digit_new, 4'hA);
        chk("two_press_digit_old", digit_old, 4'h9);

        for (int i = 0; i < 4; i++) begin
            keys = kbit(2, 3);
            repeat (5) step();
            keys = '0;
            repeat (3) step();
        end
        chk("bounce_no_early_event", n_ev, exp_ev);
        keys = kbit(2, 3);
        wait_pulse(60, n);
        exp_ev++;
        chk("bounce_pulse_in_time", int'(n > 0), 1);
        chk("bounce_code", key_code, 4'hC);
        repeat (10) step();
        for (int i = 0; i < 3; i++) begin
            keys = '0;
            repeat (3) step();
            keys = kbit(2, 3);
            repeat (2) step();
        end
        keys = '0;
        repeat (30) step();
        chk("bounce_events", n_ev, exp_ev);

        keys = kbit(0, 0) | kbit(0, 2);
        wait_pulse(60, n);
        exp_ev++;
        chk("multi_first_code", key_code, 1);
        repeat (40) step();
        chk("multi_second_suppressed", n_ev, exp_ev);
        keys = kbit(0, 2);
        wait_pulse(100, n);
        exp_ev++;
        chk("multi_rediscover_latency", n, 43);
        chk("multi_second_code", key_code, 3);
        keys = '0;
        repeat (30) step();
        chk("multi_events", n_ev, exp_ev);

        // align to the row 3 -> row 0 wrap so the press of "0" has a known phase
        pr = row;
        n = 0;
        do begin
            pr = row;
            step();
            n++;
        end while (!(pr == 4'b0111 && row == 4'b1110) && n < 40);
        chk("sync_row_wrap", int'(pr == 4'b0111 && row == 4'b1110), 1);
        keys = kbit(3, 1);
        repeat (40) step();
        chk("midreset_no_event", n_ev, exp_ev);
        do_reset();
        chk("midreset_row", row, 4'b1110);
        chk("midreset_key_valid", key_valid, 0);
        chk("midreset_key_code", key_code, 0);
        chk("midreset_digit_new", digit_new, 0);
        chk("midreset_digit_old", digit_old, 0);
        wait_pulse(60, n);
        exp_ev++;
        chk("midreset_relatch_latency", n, 48);
        chk("midreset_code", key_code, 0);
        keys = '0;
        repeat (30) step();

        for (int it = 0; it < 12; it++) begin
            r = int'($urandom_range(0, 3));
            c = int'($urandom_range(0, 3));
            nb = int'($urandom_range(0, 3));
            for (int b = 0; b < nb; b++) begin
                keys = kbit(r, c);
                repeat ($urandom_range(1, 6)) step();
                keys = '0;
                repeat ($urandom_range(1, 4)) step();
            end
            keys = kbit(r, c);
            wait_pulse(60, n);
            exp_ev++;
            chk("rand_pulse_in_time", int'(n > 0), 1);
            chk("rand_code", key_code, kmap[r][c]);
            repeat ($urandom_range(10, 80)) step();
            nb = int'($urandom_range(0, 3));
            for (int b = 0; b < nb; b++) begin
                keys = '0;
                repeat ($urandom_range(1, 6)) step();
                keys = kbit(r, c);
                repeat ($urandom_range(1, 4)) step();
            end
            keys = '0;
            repeat (30) step();
            chk("rand_events", n_ev, exp_ev);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
